// File: rtl/shift_cmd_issue.sv
// Issue stage in front of the 8-bit logical barrel shifter: buffers commands in
// an in-order FIFO, presents the head to the shifter and registers its result.
module shift_cmd_issue #(
  parameter int AW = 2,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_data,
  input  logic [2:0]    cmd_amt,
  input  logic          cmd_dir,
  output logic [W-1:0]  sh_in,
  output logic [2:0]    sh_sel,
  output logic          sh_mode,
  input  logic [W-1:0]  sh_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic [AW:0]   count
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  typedef struct packed {
    logic         dir;
    logic [2:0]   amt;
    logic [W-1:0] data;
  } cmd_t;

  cmd_t           mem [DEPTH];
  cmd_t           head;
  logic [AW-1:0]  wp, rp;
  logic           push, adv;

  // Ready comes from registered occupancy only, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign adv       = (count != '0) && (!res_valid || res_ready);
  assign head      = mem[rp];

  always_comb begin
    sh_in   = '0;
    sh_sel  = '0;
    sh_mode = 1'b0;
    if (count != '0) begin
      sh_in   = head.data;
      sh_sel  = head.amt;
      sh_mode = head.dir;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= '{dir: cmd_dir, amt: cmd_amt, data: cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (adv) begin
        rp        <= rp + 1'b1;
        res_data  <= sh_out;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, adv};
    end
  end

endmodule

// File: tb/tb_shift_cmd_issue.sv
// Scoreboarded bench for shift_cmd_issue with a behavioural logical shifter.
module tb_shift_cmd_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_dir, sh_mode, res_valid, res_ready;
  logic [7:0] cmd_data, sh_in, sh_out, res_data;
  logic [2:0] cmd_amt, sh_sel;
  logic [2:0] count;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  bit         acc;
  logic [7:0] q[$];
  logic [7:0] plog[$];
  int         pcyc[$];

  always #5 clk = ~clk;

  assign sh_out = sh_mode ? (sh_in >> sh_sel) : (sh_in << sh_sel);

  shift_cmd_issue #(.AW(2), .W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_amt(cmd_amt), .cmd_dir(cmd_dir),
    .sh_in(sh_in), .sh_sel(sh_sel), .sh_mode(sh_mode), .sh_out(sh_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .count(count)
  );

  function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] a, input logic dir);
    return dir ? (d >> a) : (d << a);
  endfunction

  // Handshakes are observed at the falling edge (inputs are stable from #1 after
  // the rising edge), then time advances to just past the next rising edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    acc = 1'b0;
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        q.push_back(shf(cmd_data, cmd_amt, cmd_dir));
        acc = 1'b1;
      end
      if (res_valid && res_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected got=%h expected=none", res_data);
        end else begin
          e = q.pop_front();
          if (res_data !== e) begin
            bad++;
            $display("FAIL sb_result got=%h expected=%h", res_data, e);
          end
        end
        plog.push_back(res_data);
        pcyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic [2:0] a, input logic dr);
    cmd_valid = v; cmd_data = d; cmd_amt = a; cmd_dir = dr;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (q.size() != 0 || count !== 3'd0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain pending=%0d count=%0d res_valid=%b required 0/0/0", q.size(), count, res_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; res_ready = 1'b0;
    drv(1'b0, 8'h00, 3'd0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    total++;
    if (count !== 3'd0 || res_valid !== 1'b0 || res_data !== 8'h00 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state count=%0d rv=%b rd=%h crdy=%b required 0/0/00/1", count, res_valid, res_data, cmd_ready);
    end
    total++;
    if (sh_in !== 8'h00 || sh_sel !== 3'd0 || sh_mode !== 1'b0) begin
      bad++;
      $display("FAIL reset_sh sh_in=%h sh_sel=%0d sh_mode=%b required 0", sh_in, sh_sel, sh_mode);
    end
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    drv(1'b1, 8'hB5, 3'd3, 1'b0);
    tick();
    drv(1'b0, 8'h00, 3'd0, 1'b0);
    total++;
    if (res_valid !== 1'b0 || count !== 3'd1 || sh_in !== 8'hB5 || sh_sel !== 3'd3 || sh_mode !== 1'b0) begin
      bad++;
      $display("FAIL basic_issue rv=%b count=%0d sh=%h/%0d/%b required 0/1/b5/3/0", res_valid, count, sh_in, sh_sel, sh_mode);
    end
    tick();
    total++;
    if (res_valid !== 1'b1 || res_data !== 8'hA8 || count !== 3'd0) begin
      bad++;
      $display("FAIL basic_result rv=%b rd=%h count=%0d required 1/a8/0", res_valid, res_data, count);
    end
    tick();
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_clear rv=%b required 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = plog.size();
    res_ready = 1'b1;
    drv(1'b1, 8'hB5, 3'd3, 1'b1); tick();
    drv(1'b1, 8'h3C, 3'd0, 1'b0); tick();
    drv(1'b1, 8'hFF, 3'd7, 1'b0); tick();
    drain();
    total++;
    if (plog.size() - n0 != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d required 3", plog.size() - n0);
    end else begin
      total++;
      if (plog[n0] !== 8'h16 || plog[n0+1] !== 8'h3C || plog[n0+2] !== 8'h80) begin
        bad++;
        $display("FAIL b2b_values got=%h %h %h required 16 3c 80", plog[n0], plog[n0+1], plog[n0+2]);
      end
      total++;
      if (pcyc[n0+1] - pcyc[n0] != 1 || pcyc[n0+2] - pcyc[n0+1] != 1) begin
        bad++;
        $display("FAIL b2b_rate gaps=%0d %0d required 1 1", pcyc[n0+1] - pcyc[n0], pcyc[n0+2] - pcyc[n0+1]);
      end
    end
  endtask

  task automatic test_capacity();
    int idx, n0;
    logic [7:0] d;
    n0 = plog.size();
    idx = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      d = 8'h21 + 8'(idx * 8'h13);
      drv(1'b1, d, 3'(idx), idx[0]);
      tick();
      if (acc) idx++;
    end
    total++;
    if (idx != 5 || count !== 3'd4 || cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
      bad++;
      $display("FAIL cap_full accepted=%0d count=%0d crdy=%b rv=%b required 5/4/0/1", idx, count, cmd_ready, res_valid);
    end
    res_ready = 1'b1;
    tick();
    total++;
    if (acc || cmd_ready !== 1'b1 || count !== 3'd3) begin
      bad++;
      $display("FAIL cap_first_pop acc=%b crdy=%b count=%0d required 0/1/3", acc, cmd_ready, count);
    end
    tick();
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL cap_sixth acc=%b required 1", acc);
    end
    drain();
    total++;
    if (plog.size() - n0 != 6) begin
      bad++;
      $display("FAIL cap_drain got=%0d required 6", plog.size() - n0);
    end
  endtask

  task automatic test_simul_wrap();
    int n0, k;
    n0 = plog.size();
    res_ready = 1'b0;
    drv(1'b1, 8'h81, 3'd1, 1'b1); tick();
    drv(1'b1, 8'h42, 3'd2, 1'b0); tick();
    drv(1'b1, 8'hC3, 3'd5, 1'b1); tick();
    total++;
    if (count !== 3'd2) begin
      bad++;
      $display("FAIL simul_pre count=%0d required 2", count);
    end
    drv(1'b1, 8'h5A, 3'd4, 1'b0);
    res_ready = 1'b1;
    tick();
    total++;
    if (!acc || count !== 3'd2) begin
      bad++;
      $display("FAIL simul_push_pop acc=%b count=%0d required 1/2", acc, count);
    end
    drain();
    k = 0;
    for (int i = 0; i < 60 && k < 10; i++) begin
      res_ready = (i % 3 != 0);
      drv(1'b1, 8'($urandom_range(255)), 3'($urandom_range(7)), 1'($urandom_range(1)));
      tick();
      if (acc) k++;
    end
    total++;
    if (k != 10) begin
      bad++;
      $display("FAIL wrap_accept got=%0d required 10", k);
    end
    drain();
    total++;
    if (plog.size() - n0 != 14) begin
      bad++;
      $display("FAIL wrap_results got=%0d required 14", plog.size() - n0);
    end
  endtask

  task automatic test_empty();
    logic [7:0] last;
    last = plog[plog.size()-1];
    total++;
    if (sh_in !== 8'h00 || sh_sel !== 3'd0 || sh_mode !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL empty_sh sh=%h/%0d/%b rv=%b required 0", sh_in, sh_sel, sh_mode, res_valid);
    end
    drv(1'b0, 8'h00, 3'd0, 1'b0);
    res_ready = 1'b1; tick();
    res_ready = 1'b0; tick();
    total++;
    if (res_valid !== 1'b0 || res_data !== last || count !== 3'd0) begin
      bad++;
      $display("FAIL empty_pulse rv=%b rd=%h count=%0d required 0/%h/0", res_valid, res_data, count, last);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    res_ready = 1'b0;
    drv(1'b1, 8'h99, 3'd1, 1'b0); tick();
    drv(1'b1, 8'h77, 3'd2, 1'b1); tick();
    drv(1'b1, 8'hE1, 3'd3, 1'b0); tick();
    drv(1'b1, 8'h0F, 3'd4, 1'b1); tick();
    drv(1'b0, 8'h00, 3'd0, 1'b0);
    total++;
    if (count !== 3'd3 || res_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_setup count=%0d rv=%b required 3/1", count, res_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    total++;
    if (count !== 3'd0 || res_valid !== 1'b0 || res_data !== 8'h00 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset count=%0d rv=%b rd=%h crdy=%b required 0/0/00/1", count, res_valid, res_data, cmd_ready);
    end
    n0 = plog.size();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (plog.size() != n0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_stale results=%0d rv=%b required 0/0", plog.size() - n0, res_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_capacity();
    test_simul_wrap();
    test_empty();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
